// File: rtl/mem_arbiter.sv
// Two-master SDRAM arbiter: video (master 0) has fixed priority, the CPU (master 1) is
// protected from starvation by a saturating wait counter. Grants are released via DRAIN.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CPU_MAX_WAIT = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_request,
  input  logic [ADDR_W-1:0] vga_address,
  input  logic              vga_last4,
  output logic              vga_ready,
  output logic [DATA_W-1:0] vga_data_read,
  input  logic              cpu_request,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_write_enable,
  input  logic [DATA_W-1:0] cpu_data_write,
  input  logic              cpu_last4,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_data_read,
  output logic              sd_request,
  output logic [ADDR_W-1:0] sd_address,
  output logic              sd_write_enable,
  output logic [DATA_W-1:0] sd_data_write,
  output logic              sd_last4,
  input  logic              sd_ready,
  input  logic [DATA_W-1:0] sd_data_read
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned WaitW  = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);
  localparam logic [WaitW-1:0]  WaitMax   = WaitW'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StVideo, StCpu, StDrain} state_e;

  state_e              r_state;
  logic                r_owner;     // 0: video, 1: CPU
  logic [DrainW-1:0]   r_drain_cnt;
  logic [WaitW-1:0]    r_wait_cnt;

  logic w_starve;
  logic w_granted;
  logic w_owner_req;

  assign w_starve    = (r_wait_cnt == WaitMax);
  assign w_granted   = (r_state == StVideo) || (r_state == StCpu);
  assign w_owner_req = r_owner ? cpu_request : vga_request;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_owner     <= 1'b0;
      r_drain_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (cpu_request && (r_state != StCpu) && (r_wait_cnt != WaitMax)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_starve && cpu_request) begin
            r_state    <= StCpu;
            r_owner    <= 1'b1;
            r_wait_cnt <= '0;
          end else if (vga_request) begin
            r_state <= StVideo;
            r_owner <= 1'b0;
          end else if (cpu_request) begin
            r_state    <= StCpu;
            r_owner    <= 1'b1;
            r_wait_cnt <= '0;
          end
        end
        StVideo, StCpu: begin
          if (!w_owner_req) begin
            r_state     <= StDrain;
            r_drain_cnt <= '0;
          end
        end
        StDrain: begin
          // A late word restarts the quiet window so no in-flight data is misrouted.
          if (sd_ready) begin
            r_drain_cnt <= '0;
          end else if (r_drain_cnt == DrainLast) begin
            r_state <= StIdle;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Zero-latency pass-through of the owning master while granted.
  always_comb begin
    sd_request      = 1'b0;
    sd_address      = '0;
    sd_write_enable = 1'b0;
    sd_data_write   = '0;
    sd_last4        = 1'b0;
    if (w_granted) begin
      if (r_owner) begin
        sd_request      = cpu_request;
        sd_address      = cpu_address;
        sd_write_enable = cpu_write_enable;
        sd_data_write   = cpu_data_write;
        sd_last4        = cpu_last4;
      end else begin
        sd_request = vga_request;
        sd_address = vga_address;
        sd_last4   = vga_last4;
      end
    end
  end

  assign vga_ready     = sd_ready && !r_owner && (r_state != StIdle);
  assign cpu_ready     = sd_ready && r_owner && (r_state != StIdle);
  assign vga_data_read = sd_data_read;
  assign cpu_data_read = sd_data_read;

endmodule
